// File: rtl/signal_narrowing_pkg.sv
// Shared constants and FSM encoding for the 16-to-11 bit signed narrowing stage.
`timescale 1ns/1ps
package signal_narrowing_pkg;

  localparam int DATA_W    = 16;
  localparam int OPERAND_W = 11;

  localparam logic [OPERAND_W-1:0] OPERAND_MAX = 11'h3FF;
  localparam logic [OPERAND_W-1:0] OPERAND_MIN = 11'h400;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/signal_narrowing_narrow_core.sv
// Combinational narrowing of a signed IN_W value to OUT_W bits with overflow flag.
// SIGNAL_NARROWING_SAT_EN selects saturation on overflow; otherwise the value wraps.
`timescale 1ns/1ps
module narrow_core
  import signal_narrowing_pkg::*;
#(
  parameter int IN_W  = DATA_W,
  parameter int OUT_W = OPERAND_W
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  // The value fits only if every bit from the MSB down to the new sign bit agrees.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = in_data[IN_W-1:OUT_W-1];
  assign ovf      = ~((&top_bits) | ~(|top_bits));

`ifdef SIGNAL_NARROWING_SAT_EN
  always_comb begin
    out_data = in_data[OUT_W-1:0];
    if (ovf) begin
      out_data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign out_data = in_data[OUT_W-1:0];
`endif

endmodule

// File: rtl/signal_narrowing.sv
// Registered valid/ready narrowing stage between the ALU result and operand write-back.
// Build option SIGNAL_NARROWING_SAT_EN: saturate overflowing values instead of wrapping.
`timescale 1ns/1ps
module signal_narrowing
  import signal_narrowing_pkg::*;
#(
  parameter int IN_W  = DATA_W,
  parameter int OUT_W = OPERAND_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_stats,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  state_e           state;
  logic [OUT_W-1:0] core_data;
  logic             core_ovf;
  logic             accept;
  logic             drain;

  narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .out_data (core_data),
    .ovf      (core_ovf)
  );

  // A full stage can still take a word when the consumer drains it the same cycle.
  assign in_ready  = (state == ST_EMPTY) | out_ready;
  assign out_valid = (state == ST_FULL);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      if (accept) begin
        state    <= ST_FULL;
        out_data <= core_data;
        out_ovf  <= core_ovf;
      end else if (drain) begin
        state <= ST_EMPTY;
      end

      // Clearing wins over a simultaneous overflow, which is then not counted.
      if (clr_stats) begin
        ovf_sticky <= 1'b0;
        ovf_count  <= '0;
      end else if (accept && core_ovf) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != {CNT_W{1'b1}}) begin
          ovf_count <= ovf_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
